// File: rtl/pc_if.sv
// Bus between the next-PC logic (master) and the program-counter unit (slave).
// Width and CountWidth must match the pc_unit instance the interface is bound to.
interface pc_if #(
  parameter int unsigned Width      = 32,
  parameter int unsigned CountWidth = 32
);
  logic                  PCstall;
  logic                  PCredirect;
  logic [Width-1:0]      PCtarget;
  logic                  PChalt;
  logic                  PCresume;
  logic                  PCtrap;
  logic                  PCmret;
  logic [Width-1:0]      PCaddress;
  logic [Width-1:0]      PCplus;
  logic [Width-1:0]      PCepc;
  logic [1:0]            PCcause;
  logic                  PChalted;
  logic [CountWidth-1:0] PCcount;

  modport master (
    output PCstall, PCredirect, PCtarget, PChalt, PCresume, PCtrap, PCmret,
    input  PCaddress, PCplus, PCepc, PCcause, PChalted, PCcount
  );

  modport slave (
    input  PCstall, PCredirect, PCtarget, PChalt, PCresume, PCtrap, PCmret,
    output PCaddress, PCplus, PCepc, PCcause, PChalted, PCcount
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: owns the fetch address, with RUN/HALT control and an advance counter.
// Define PC_TRAP_EN to enable trap entry, misaligned-target detection, mret, PCepc and PCcause.
module pc_unit #(
  parameter int unsigned      Width       = 32,
  parameter logic [Width-1:0] ResetVector = '0,
  parameter logic [Width-1:0] TrapVector  = Width'(32'h0000_0100),
  parameter int unsigned      CountWidth  = 32
) (
  input logic  clk,
  input logic  PCrst,
  pc_if.slave  bus
);

  typedef enum logic {RUN, HALT} state_e;

  state_e                state_q;
  logic [Width-1:0]      addr_q;
  logic [CountWidth-1:0] count_q;
  logic [Width-1:0]      pc_plus;

  assign pc_plus = addr_q + Width'(4);

`ifdef PC_TRAP_EN
  localparam logic [1:0] CauseExternal   = 2'd1;
  localparam logic [1:0] CauseMisaligned = 2'd2;

  logic [Width-1:0] epc_q;
  logic [1:0]       cause_q;
  logic             misaligned;

  assign misaligned = bus.PCredirect && (bus.PCtarget[1:0] != 2'b00);
`endif

  // NOTE: every register here is written with <= inside one clocked block so all
  // updates take effect together at the edge; the async reset clears them without a clock.
  always_ff @(posedge clk or posedge PCrst) begin
    if (PCrst) begin
      state_q <= RUN;
      addr_q  <= ResetVector;
      count_q <= '0;
`ifdef PC_TRAP_EN
      epc_q   <= '0;
      cause_q <= 2'd0;
`endif
    end else begin
      case (state_q)
        RUN: begin
`ifdef PC_TRAP_EN
          if (bus.PCtrap || misaligned) begin
            epc_q   <= addr_q;
            cause_q <= bus.PCtrap ? CauseExternal : CauseMisaligned;
            addr_q  <= TrapVector;
            count_q <= count_q + CountWidth'(1);
          end else if (bus.PCmret) begin
            addr_q  <= epc_q;
            count_q <= count_q + CountWidth'(1);
          end else
`endif
          if (bus.PChalt) begin
            state_q <= HALT;
          end else if (bus.PCredirect) begin
            // Low bits are zero here in the trap build; otherwise they are silently dropped.
            addr_q  <= {bus.PCtarget[Width-1:2], 2'b00};
            count_q <= count_q + CountWidth'(1);
          end else if (!bus.PCstall) begin
            addr_q  <= pc_plus;
            count_q <= count_q + CountWidth'(1);
          end
        end
        HALT: begin
`ifdef PC_TRAP_EN
          if (bus.PCtrap) begin
            epc_q   <= addr_q;
            cause_q <= CauseExternal;
            addr_q  <= TrapVector;
            count_q <= count_q + CountWidth'(1);
            state_q <= RUN;
          end else
`endif
          if (bus.PCresume) begin
            addr_q  <= pc_plus;
            count_q <= count_q + CountWidth'(1);
            state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.PCaddress = addr_q;
  assign bus.PCplus    = pc_plus;
  assign bus.PChalted  = (state_q == HALT);
  assign bus.PCcount   = count_q;

`ifdef PC_TRAP_EN
  assign bus.PCepc   = epc_q;
  assign bus.PCcause = cause_q;
`else
  logic unused_trap_inputs;
  assign unused_trap_inputs = ^{bus.PCtrap, bus.PCmret, bus.PCtarget[1:0]};
  assign bus.PCepc   = '0;
  assign bus.PCcause = 2'd0;
`endif

endmodule
